demux4_router: RTL and testbench

- Inverse of the 4:1 mux: takes one input word stream and routes each word to one of four output channels.
- Each channel has a single-entry holding register with a valid/ready handshake.
- The destination is either the explicit `in_sel` or an internal round-robin pointer.
- Used wherever a shared datapath fans out to four consumers.

---
 rtl/demux4_router_if.sv | 26 ++
 rtl/demux4_router.sv | 60 ++++++
 tb/tb_demux4_router.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/demux4_router_if.sv
// Handshake bundle between the 1:4 router and its surroundings.
// The slave modport is the router's view; the master modport is the upstream/consumer side.
interface demux4_router_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic [1:0]         in_sel;
  logic               auto_mode;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [1:0]         rr_ptr;
  logic               busy;

  modport slave (
    input  in_data, in_valid, in_sel, auto_mode, out_ready,
    output in_ready, out_data, out_valid, rr_ptr, busy
  );

  modport master (
    output in_data, in_valid, in_sel, auto_mode, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr, busy
  );
endinterface

// File: rtl/demux4_router.sv
// 1:4 word router: each input word goes to one of four single-entry channel registers,
// chosen by in_sel or by an internal round-robin pointer.
module demux4_router #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  demux4_router_if.slave  bus
);

  logic [3:0][WIDTH-1:0] r_data;
  logic [3:0]            r_valid;
  logic [1:0]            r_rr_ptr;

  logic [1:0]            w_eff_sel;
  logic                  w_in_ready;
  logic                  w_accept;
  logic [3:0]            w_load;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_eff_sel  = bus.auto_mode ? r_rr_ptr : bus.in_sel;
    // A full channel can still take a word when its consumer drains it in the same cycle.
    w_in_ready = !reset && (!r_valid[w_eff_sel] || bus.out_ready[w_eff_sel]);
    w_accept   = bus.in_valid && w_in_ready;
    w_load     = 4'b0000;
    if (w_accept) begin
      w_load = 4'b0001 << w_eff_sel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_valid  <= 4'b0000;
      r_rr_ptr <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_data[i]  <= bus.in_data;
          r_valid[i] <= 1'b1;
        end else if (bus.out_ready[i]) begin
          // Drained data is left in place; only the valid flag drops.
          r_valid[i] <= 1'b0;
        end
      end
      if (w_accept && bus.auto_mode) begin
        r_rr_ptr <= r_rr_ptr + 2'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.rr_ptr    = r_rr_ptr;
  assign bus.busy      = |r_valid;

endmodule

// File: tb/tb_demux4_router.sv
// Directed self-checking bench for demux4_router: reset, explicit routing, stall/drain,
// back-to-back throughput, round robin, pointer hold and reset mid-operation.
module tb_demux4_router;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  demux4_router_if #(.WIDTH(W)) bus ();

  demux4_router #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] slice(input int k);
    return bus.out_data[k*W +: W];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.auto_mode = 1'b0;
    bus.in_data = '0; bus.out_ready = 4'b0000;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low got=%b exp=0", bus.in_ready); end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
    total++;
    if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    total++;
    if (bus.rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_rr_ptr got=%0d exp=0", bus.rr_ptr); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_explicit();
    logic [W-1:0] words [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [W-1:0] exp_d [4] = '{default: '0};
    logic [3:0]   exp_v = 4'b0000;
    bus.auto_mode = 1'b0;
    bus.out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      bus.in_sel = k[1:0]; bus.in_data = words[k]; bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL explicit_in_ready ch%0d got=%b exp=1", k, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      exp_d[k] = words[k];
      exp_v[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        total++;
        if (slice(j) !== exp_d[j]) begin bad++; $display("FAIL explicit_data after ch%0d slice%0d got=%h exp=%h", k, j, slice(j), exp_d[j]); end
      end
      total++;
      if (bus.out_valid !== exp_v) begin bad++; $display("FAIL explicit_valid after ch%0d got=%b exp=%b", k, bus.out_valid, exp_v); end
    end
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL explicit_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic test_stall_drain();
    bus.in_sel = 2'd2; bus.in_data = 8'h55; bus.in_valid = 1'b1; bus.out_ready = 4'b0000;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    total++;
    if (slice(2) !== 8'hC3) begin bad++; $display("FAIL stall_hold got=%h exp=c3", slice(2)); end
    bus.out_ready = 4'b0100;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    total++;
    if (slice(2) !== 8'h55) begin bad++; $display("FAIL replace_data got=%h exp=55", slice(2)); end
    total++;
    if (bus.out_valid !== 4'b1111) begin bad++; $display("FAIL replace_valid got=%b exp=1111", bus.out_valid); end
    // Plain drain of channel 0: valid drops, data stays.
    bus.out_ready = 4'b0001;
    tick();
    bus.out_ready = 4'b0000;
    total++;
    if (bus.out_valid !== 4'b1110) begin bad++; $display("FAIL drain_valid got=%b exp=1110", bus.out_valid); end
    total++;
    if (slice(0) !== 8'hA1) begin bad++; $display("FAIL drain_data_kept got=%h exp=a1", slice(0)); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3] = '{8'hE0, 8'hE1, 8'hE2};
    bus.auto_mode = 1'b0; bus.in_sel = 2'd1; bus.out_ready = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = words[k]; bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready word%0d got=%b exp=1", k, bus.in_ready); end
      tick();
      total++;
      if (slice(1) !== words[k]) begin bad++; $display("FAIL b2b_data word%0d got=%h exp=%h", k, slice(1), words[k]); end
      total++;
      if (bus.out_valid !== 4'b1110) begin bad++; $display("FAIL b2b_valid word%0d got=%b exp=1110", k, bus.out_valid); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
  endtask

  task automatic test_round_robin();
    int ch;
    bus.auto_mode = 1'b1; bus.out_ready = 4'b1111; bus.in_sel = 2'd3;
    for (int k = 0; k < 6; k++) begin
      ch = k % 4;
      bus.in_data = 8'h10 + W'(k); bus.in_valid = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rr_in_ready word%0d got=%b exp=1", k, bus.in_ready); end
      total++;
      if (bus.rr_ptr !== ch[1:0]) begin bad++; $display("FAIL rr_ptr_before word%0d got=%0d exp=%0d", k, bus.rr_ptr, ch); end
      tick();
      total++;
      if (slice(ch) !== 8'h10 + W'(k)) begin bad++; $display("FAIL rr_data word%0d ch%0d got=%h exp=%h", k, ch, slice(ch), 8'h10 + k); end
      total++;
      if (bus.out_valid !== (4'b0001 << ch)) begin bad++; $display("FAIL rr_valid word%0d got=%b exp=%b", k, bus.out_valid, 4'b0001 << ch); end
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.rr_ptr !== 2'd2) begin bad++; $display("FAIL rr_ptr_final got=%0d exp=2", bus.rr_ptr); end
  endtask

  task automatic test_pointer_hold();
    bus.out_ready = 4'b0000; bus.in_valid = 1'b0; bus.auto_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.rr_ptr !== 2'd2) begin bad++; $display("FAIL hold_idle cyc%0d got=%0d exp=2", k, bus.rr_ptr); end
    end
    bus.auto_mode = 1'b0; bus.in_sel = 2'd3; bus.in_data = 8'h77; bus.in_valid = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (slice(3) !== 8'h77) begin bad++; $display("FAIL hold_explicit_data got=%h exp=77", slice(3)); end
    total++;
    if (bus.rr_ptr !== 2'd2) begin bad++; $display("FAIL hold_explicit_ptr got=%0d exp=2", bus.rr_ptr); end
    bus.auto_mode = 1'b1;
    tick();
    total++;
    if (bus.rr_ptr !== 2'd2) begin bad++; $display("FAIL hold_toggle_ptr got=%0d exp=2", bus.rr_ptr); end
  endtask

  task automatic test_reset_mid();
    // Channel 1 holds 8'h15 and channel 3 holds 8'h77; add channel 0 to reach 1011.
    bus.auto_mode = 1'b0; bus.in_sel = 2'd0; bus.in_data = 8'h88; bus.in_valid = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 4'b1011) begin bad++; $display("FAIL mid_setup_valid got=%b exp=1011", bus.out_valid); end
    bus.in_sel = 2'd2; bus.in_data = 8'h99; bus.in_valid = 1'b1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 4'b0000) begin bad++; $display("FAIL mid_out_valid got=%b exp=0000", bus.out_valid); end
    total++;
    if (bus.out_data !== '0) begin bad++; $display("FAIL mid_out_data got=%h exp=0", bus.out_data); end
    total++;
    if (bus.rr_ptr !== 2'd0) begin bad++; $display("FAIL mid_rr_ptr got=%0d exp=0", bus.rr_ptr); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_stall_drain();
    test_back_to_back();
    test_round_robin();
    test_pointer_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
